// File: rtl/onn_pkg.sv
// rtl/onn_pkg.sv - shared state encoding and default parameters for the ONN sequencer
package onn_pkg;

  localparam int ONN_N               = 210;
  localparam int ONN_LOAD_PER_NEURON = 4;
  localparam int ONN_SETTLE          = 17;
  localparam int ONN_MAX_ITER        = 255;
  localparam int ONN_STABLE_CHECKS   = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_INIT   = 3'd2,
    ST_UPDATE = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_DONE   = 3'd6,
    ST_FAIL   = 3'd7
  } onn_state_t;

  // IDLE, DONE and FAIL are the resting states; everything else is an active run.
  function automatic logic onn_is_busy(onn_state_t s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_FAIL);
  endfunction

endpackage

// File: rtl/onn_seq_ctrl.sv
// rtl/onn_seq_ctrl.sv - load / init / update / settle / check sequencer for an oscillator network
module onn_seq_ctrl
  import onn_pkg::*;
#(
  parameter int N               = ONN_N,
  parameter int LOAD_PER_NEURON = ONN_LOAD_PER_NEURON,
  parameter int SETTLE          = ONN_SETTLE,
  parameter int MAX_ITER        = ONN_MAX_ITER,
  parameter int STABLE_CHECKS   = ONN_STABLE_CHECKS
) (
  input  logic                                        sclk,
  input  logic                                        re,
  input  logic                                        load,
  input  logic                                        abort,
  input  logic [N-1:0]                                state_changed,
  output logic                                        re_n,
  output logic                                        drop,
  output logic                                        state_cheak,
  output logic                                        phi_to_no,
  output logic                                        timeout,
  output logic                                        busy,
  output logic [$clog2(N*LOAD_PER_NEURON+1)-1:0]      load_cnt,
  output logic [$clog2(MAX_ITER+1)-1:0]               iter_cnt
);

  localparam int LOAD_W   = $clog2(N*LOAD_PER_NEURON+1);
  localparam int ITER_W   = $clog2(MAX_ITER+1);
  localparam int SETTLE_W = (SETTLE < 1) ? 1 : $clog2(SETTLE+1);

  localparam logic [LOAD_W-1:0]   LOAD_LAST     = LOAD_W'(N*LOAD_PER_NEURON);
  localparam logic [ITER_W-1:0]   ITER_LAST     = ITER_W'(MAX_ITER);
  localparam logic [SETTLE_W-1:0] SETTLE_LAST   = SETTLE_W'(SETTLE);
  localparam logic [3:0]          STABLE_TARGET = 4'(STABLE_CHECKS);

  onn_state_t            state_q, state_d;
  logic [SETTLE_W-1:0]   settle_cnt;
  logic [3:0]            stable_q, stable_d;
  logic                  any_changed;

  assign any_changed = |state_changed;

  // State register; reset wins over everything else.
  always_ff @(posedge sclk) begin
    if (re) state_q <= ST_IDLE;
    else    state_q <= state_d;
  end

  // Next-state and stable-run bookkeeping; abort overrides any transition.
  always_comb begin
    state_d  = state_q;
    stable_d = stable_q;
    case (state_q)
      ST_IDLE:   if (load) state_d = ST_LOAD;
      ST_LOAD:   if (load_cnt == LOAD_LAST) state_d = ST_INIT;
      ST_INIT:   state_d = ST_UPDATE;
      ST_UPDATE: state_d = (SETTLE == 0) ? ST_CHECK : ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST) state_d = ST_CHECK;
      ST_CHECK: begin
        if (any_changed) stable_d = '0;
        else             stable_d = stable_q + 4'd1;
        // Convergence is judged before the iteration limit, so the last allowed
        // check can still end in DONE.
        if (!any_changed && stable_d == STABLE_TARGET) state_d = ST_DONE;
        else if (iter_cnt == ITER_LAST)                state_d = ST_FAIL;
        else                                           state_d = ST_UPDATE;
      end
      ST_DONE, ST_FAIL: begin
        if (load) begin
          state_d  = ST_LOAD;
          stable_d = '0;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
    if (abort) begin
      state_d  = ST_IDLE;
      stable_d = '0;
    end
  end

  // Counters follow the state being entered so they line up with the registered outputs.
  always_ff @(posedge sclk) begin
    if (re) begin
      load_cnt   <= '0;
      iter_cnt   <= '0;
      settle_cnt <= '0;
      stable_q   <= '0;
    end else begin
      stable_q <= stable_d;

      if (state_d == ST_IDLE) begin
        load_cnt <= '0;
      end else if (state_d == ST_LOAD) begin
        if (state_q != ST_LOAD)        load_cnt <= LOAD_W'(1);
        else if (load_cnt != LOAD_LAST) load_cnt <= load_cnt + LOAD_W'(1);
      end

      if (state_d == ST_IDLE || state_d == ST_LOAD) begin
        iter_cnt <= '0;
      end else if (state_d == ST_UPDATE && iter_cnt != ITER_LAST) begin
        iter_cnt <= iter_cnt + ITER_W'(1);
      end

      if (state_d != ST_SETTLE)      settle_cnt <= '0;
      else if (state_q != ST_SETTLE) settle_cnt <= SETTLE_W'(1);
      else if (settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + SETTLE_W'(1);
    end
  end

  // Registered pulse and flag outputs decoded from the state being entered.
  always_ff @(posedge sclk) begin
    if (re) begin
      re_n        <= 1'b0;
      drop        <= 1'b0;
      state_cheak <= 1'b0;
      phi_to_no   <= 1'b0;
      timeout     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      re_n        <= (state_d == ST_UPDATE);
      drop        <= (state_d == ST_INIT);
      state_cheak <= (state_d == ST_CHECK);
      phi_to_no   <= (state_d == ST_DONE);
      timeout     <= (state_d == ST_FAIL);
      busy        <= onn_is_busy(state_d);
    end
  end

endmodule

// File: tb/tb_onn_seq_ctrl.sv
// tb/tb_onn_seq_ctrl.sv - randomized self-checking bench for onn_seq_ctrl
module tb_onn_seq_ctrl;

  localparam int TN   = 4;
  localparam int TLPN = 4;
  localparam int TS   = 3;
  localparam int TMAX = 5;
  localparam int TSC  = 2;
  localparam int LT   = TN * TLPN;

  typedef struct packed {
    logic       re_n;
    logic       drop;
    logic       chk;
    logic       phi;
    logic       tmo;
    logic       busy;
    logic [4:0] lc;
    logic [2:0] it;
  } exp_t;

  logic          sclk;
  logic          re;
  logic          load;
  logic          abort;
  logic [TN-1:0] state_changed;
  logic          re_n;
  logic          drop;
  logic          state_cheak;
  logic          phi_to_no;
  logic          timeout;
  logic          busy;
  logic [4:0]    load_cnt;
  logic [2:0]    iter_cnt;

  exp_t obs;
  assign obs = {re_n, drop, state_cheak, phi_to_no, timeout, busy, load_cnt, iter_cnt};

  int compared   = 0;
  int mismatched = 0;

  exp_t       sched[$];
  logic [3:0] drv[$];
  bit         chg_q[$];
  exp_t       fin;
  exp_t       rest;

  onn_seq_ctrl #(
    .N(TN), .LOAD_PER_NEURON(TLPN), .SETTLE(TS), .MAX_ITER(TMAX), .STABLE_CHECKS(TSC)
  ) dut (
    .sclk(sclk), .re(re), .load(load), .abort(abort), .state_changed(state_changed),
    .re_n(re_n), .drop(drop), .state_cheak(state_cheak), .phi_to_no(phi_to_no),
    .timeout(timeout), .busy(busy), .load_cnt(load_cnt), .iter_cnt(iter_cnt)
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  function automatic exp_t mk(bit rn, bit dr, bit ck, bit ph, bit tm, bit bs, int lc, int it);
    exp_t e;
    e.re_n = rn; e.drop = dr; e.chk = ck; e.phi = ph; e.tmo = tm; e.busy = bs;
    e.lc = 5'(lc); e.it = 3'(it);
    return e;
  endfunction

  // Expected per-cycle trace of one run: LOAD x LT, INIT, then UPDATE/SETTLE x TS/CHECK
  // rounds until TSC consecutive quiet checks or TMAX rounds.
  task automatic build(input logic [3:0] chg_val);
    int st;
    sched.delete();
    drv.delete();
    for (int c = 1; c <= LT; c++) begin
      sched.push_back(mk(0, 0, 0, 0, 0, 1, c, 0));
      drv.push_back(4'($urandom));
    end
    sched.push_back(mk(0, 1, 0, 0, 0, 1, LT, 0));
    drv.push_back(4'($urandom));
    st = 0;
    for (int i = 1; i <= TMAX; i++) begin
      sched.push_back(mk(1, 0, 0, 0, 0, 1, LT, i));
      drv.push_back(4'($urandom));
      for (int s = 0; s < TS; s++) begin
        sched.push_back(mk(0, 0, 0, 0, 0, 1, LT, i));
        drv.push_back(4'($urandom));
      end
      sched.push_back(mk(0, 0, 1, 0, 0, 1, LT, i));
      if (chg_q[i-1]) drv.push_back((chg_val != 4'd0) ? chg_val : 4'($urandom_range(1, 15)));
      else            drv.push_back(4'd0);
      if (chg_q[i-1]) st = 0;
      else            st++;
      if (st == TSC) begin
        fin = mk(0, 0, 0, 1, 0, 0, LT, i);
        break;
      end
      if (i == TMAX) fin = mk(0, 0, 0, 0, 1, 0, LT, i);
    end
  endtask

  task automatic run_seq(input string name, input int abort_at, input int reset_at);
    @(negedge sclk);
    compared++;
    if (obs !== rest) begin
      mismatched++;
      $display("FAIL %s start: got %h expected %h", name, obs, rest);
    end
    load = 1'b1; abort = 1'b0; re = 1'b0; state_changed = 4'($urandom);
    for (int j = 0; j < sched.size(); j++) begin
      @(negedge sclk);
      compared++;
      if (obs !== sched[j]) begin
        mismatched++;
        $display("FAIL %s cycle %0d: got %h expected %h", name, j + 1, obs, sched[j]);
      end
      load          = sched[j].re_n ? 1'b1 : 1'($urandom);
      state_changed = drv[j];
      abort         = (j == abort_at);
      re            = (j == reset_at);
      if (abort || re) begin
        @(negedge sclk);
        compared++;
        if (obs !== exp_t'(0)) begin
          mismatched++;
          $display("FAIL %s after kill: got %h expected 0", name, obs);
        end
        load = 1'b0; abort = 1'b0; re = 1'b0;
        rest = '0;
        return;
      end
    end
    for (int h = 0; h < 3; h++) begin
      @(negedge sclk);
      compared++;
      if (obs !== fin) begin
        mismatched++;
        $display("FAIL %s hold %0d: got %h expected %h", name, h, obs, fin);
      end
      load = 1'b0;
      state_changed = 4'($urandom);
    end
    rest = fin;
  endtask

  task automatic test_reset();
    re = 1'b1; load = 1'b1; abort = 1'b1; state_changed = 4'hF;
    repeat (2) @(posedge sclk);
    @(negedge sclk);
    compared++;
    if (obs !== exp_t'(0)) begin
      mismatched++;
      $display("FAIL reset_hold: got %h expected 0", obs);
    end
    re = 1'b0; load = 1'b0; abort = 1'b0;
    @(negedge sclk);
    compared++;
    if (obs !== exp_t'(0)) begin
      mismatched++;
      $display("FAIL reset_idle: got %h expected 0", obs);
    end
    rest = '0;
  endtask

  task automatic test_converge();
    chg_q.delete();
    for (int i = 0; i < TMAX; i++) chg_q.push_back(1'b0);
    build(4'd0);
    run_seq("converge", -1, -1);
    compared++;
    if (obs !== mk(0, 0, 0, 1, 0, 0, 16, 2)) begin
      mismatched++;
      $display("FAIL converge_final: got %h expected %h", obs, mk(0, 0, 0, 1, 0, 0, 16, 2));
    end
  endtask

  task automatic test_timeout();
    chg_q.delete();
    for (int i = 0; i < TMAX; i++) chg_q.push_back(1'b1);
    build(4'b0010);
    run_seq("timeout", -1, -1);
    compared++;
    if (obs !== mk(0, 0, 0, 0, 1, 0, 16, 5)) begin
      mismatched++;
      $display("FAIL timeout_final: got %h expected %h", obs, mk(0, 0, 0, 0, 1, 0, 16, 5));
    end
  endtask

  task automatic test_pattern();
    chg_q.delete();
    chg_q.push_back(1'b1); chg_q.push_back(1'b0); chg_q.push_back(1'b1);
    chg_q.push_back(1'b0); chg_q.push_back(1'b0);
    build(4'd0);
    run_seq("pattern", -1, -1);
    compared++;
    if (obs !== mk(0, 0, 0, 1, 0, 0, 16, 5)) begin
      mismatched++;
      $display("FAIL pattern_final: got %h expected %h", obs, mk(0, 0, 0, 1, 0, 0, 16, 5));
    end
  endtask

  task automatic test_reload();
    @(negedge sclk);
    load = 1'b1;
    @(negedge sclk);
    compared++;
    if (obs !== mk(0, 0, 0, 0, 0, 1, 1, 0)) begin
      mismatched++;
      $display("FAIL reload_from_done: got %h expected %h", obs, mk(0, 0, 0, 0, 0, 1, 1, 0));
    end
    load = 1'b0; abort = 1'b1;
    @(negedge sclk);
    compared++;
    if (obs !== exp_t'(0)) begin
      mismatched++;
      $display("FAIL abort_in_load: got %h expected 0", obs);
    end
    abort = 1'b0;
    rest = '0;
  endtask

  task automatic test_abort();
    chg_q.delete();
    for (int i = 0; i < TMAX; i++) chg_q.push_back(1'($urandom));
    build(4'd0);
    run_seq("abort_settle", LT + 2, -1);
    build(4'd0);
    run_seq("reset_load", -1, 5);
    @(negedge sclk);
    load = 1'b1; abort = 1'b1;
    @(negedge sclk);
    compared++;
    if (obs !== exp_t'(0)) begin
      mismatched++;
      $display("FAIL abort_over_load: got %h expected 0", obs);
    end
    load = 1'b0; abort = 1'b0;
    rest = '0;
  endtask

  task automatic test_random();
    int ab;
    for (int r = 0; r < 8; r++) begin
      chg_q.delete();
      for (int i = 0; i < TMAX; i++) chg_q.push_back($urandom_range(0, 2) == 0);
      build(4'd0);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, sched.size() - 1)) : -1;
      run_seq("random", ab, -1);
    end
  endtask

  initial begin
    re = 1'b1; load = 1'b0; abort = 1'b0; state_changed = '0; rest = '0; fin = '0;
    test_reset();
    test_converge();
    test_timeout();
    test_pattern();
    test_reload();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/onn_seq_ctrl.md
ONN_SEQ_CTRL -- requirements
Module: onn_seq_ctrl

Interface
REQ-001 Parameter N, default 210: number of oscillator neurons and width of state_changed.
REQ-002 Parameter LOAD_PER_NEURON, default 4: load cycles per neuron; load phase is N*LOAD_PER_NEURON cycles.
REQ-003 Parameter SETTLE, default 17: settle cycles after each update pulse.
REQ-004 Parameter MAX_ITER, default 255: update iterations allowed before timeout.
REQ-005 Parameter STABLE_CHECKS, default 1, range 1..15: consecutive no-change checks required for convergence.
REQ-006 Ports SHALL be:
- sclk  in  1: single clock, rising edge.
- re  in  1: reset, synchronous, active-high.
- load  in  1: start request.
- abort  in  1: return to idle.
- state_changed  in  N: per-neuron change flags.
- re_n  out  1: phase-update pulse.
- drop  out  1: init pulse after load.
- state_cheak  out  1: check-strobe.
- phi_to_no  out  1: converged flag.
- timeout  out  1: iteration limit reached.
- busy  out  1: not IDLE/DONE/FAIL.
- load_cnt  out  clog2(N*LOAD_PER_NEURON+1): load counter.
- iter_cnt  out  clog2(MAX_ITER+1): completed update pulses.

Function
REQ-007 States SHALL be IDLE, LOAD, INIT, UPDATE, SETTLE, CHECK, DONE, FAIL; outputs are registered and decoded from the state the FSM occupies in that cycle.
REQ-008 IDLE: load=1 sampled -> LOAD next cycle; otherwise stay.
REQ-009 LOAD: load_cnt increments each LOAD cycle starting from 1; after exactly N*LOAD_PER_NEURON LOAD cycles -> INIT; load_cnt then holds its final value.
REQ-010 INIT: drop=1 for exactly one cycle -> UPDATE.
REQ-011 UPDATE: re_n=1 for exactly one cycle, iter_cnt increments -> SETTLE.
REQ-012 SETTLE: exactly SETTLE cycles, all pulses low -> CHECK.
REQ-013 CHECK: state_cheak=1 for one cycle; state_changed sampled in this cycle only.
REQ-014 CHECK with any state_changed bit set: stable counter cleared; iter_cnt==MAX_ITER -> FAIL, else -> UPDATE.
REQ-015 CHECK with state_changed all zero: stable counter increments; new value == STABLE_CHECKS -> DONE; otherwise, if iter_cnt==MAX_ITER -> FAIL, else -> UPDATE.
REQ-016 DONE: phi_to_no=1 held; FAIL: timeout=1 held; both persist until reset, abort, or load.
REQ-017 load=1 in DONE or FAIL -> LOAD; load_cnt, iter_cnt, stable counter cleared and flags dropped in the same transition.
REQ-018 load is ignored in every state other than IDLE, DONE, FAIL.
REQ-019 abort=1 in any state -> IDLE next cycle, all counters and outputs cleared; abort has priority over load.
REQ-020 Counters SHALL NOT wrap: load_cnt saturates at N*LOAD_PER_NEURON, iter_cnt at MAX_ITER.

Reset
REQ-021 re=1 at a sclk edge SHALL force IDLE, clear all counters, and drive every output to 0; it has priority over abort and load.
REQ-022 Reset asserted mid-operation (any state) SHALL take effect on the same edge with no residual pulse afterwards.

Structure
REQ-023 State encoding constants and the default parameter values SHALL live in the shared package onn_pkg.
REQ-024 Single module, no sub-modules; the N-bit OR reduction of state_changed is inline.

Verification (N=4, LOAD_PER_NEURON=4, SETTLE=3, MAX_ITER=5, STABLE_CHECKS=2)
REQ-025 Reset, then load=1 at cycle 0 -> LOAD cycles 1-16 with load_cnt 1..16, drop at 17, re_n at 18, state_cheak at 22.
REQ-026 state_changed=0 at every check -> checks at 22 and 27, phi_to_no=1 from cycle 28, iter_cnt=2, busy=0.
REQ-027 state_changed=4'b0010 at every check -> five re_n pulses, timeout=1 after the fifth check, iter_cnt=5.
REQ-028 Pattern changed/stable/changed/stable/stable -> stable counter restarts on each change, DONE after the fifth check, iter_cnt=5, timeout=0.
REQ-029 abort during SETTLE, or re during LOAD -> IDLE next edge, all outputs 0; a load issued mid-UPDATE is ignored.
REQ-030 load=1 while in DONE -> LOAD next cycle, phi_to_no=0, load_cnt=1, iter_cnt=0.
